// File: rtl/seg_clock_ctrl.sv
// rtl/seg_clock_ctrl.sv - BCD HH:MM[:SS] timekeeper with two-button set FSM and muxed 7-segment drive
// Optional alarm (ports alarm_on/alarm, alarm set states) enabled by SEG_CLOCK_ALARM_EN.
module seg_clock_ctrl #(
  parameter int CLK_HZ            = 12000000,
  parameter int NUM_DIGITS        = 4,
  parameter int SCAN_DIV_LOG2     = 10,
  parameter int DEBOUNCE_DIV_LOG2 = 15,
  parameter int REPEAT_DELAY      = 256,
  parameter int REPEAT_PERIOD     = 64
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  btn_set,
  input  logic                  btn_inc,
  input  logic                  mode_12h,
`ifdef SEG_CLOCK_ALARM_EN
  input  logic                  alarm_on,
  output logic                  alarm,
`endif
  output logic [7:0]            seg,
  output logic [NUM_DIGITS-1:0] d,
  output logic [23:0]           time_bcd
);
  localparam int PW = $clog2(CLK_HZ);
  localparam int RW = $clog2(REPEAT_DELAY + 1);
  localparam logic [PW-1:0] P_ONE      = PW'(1);
  localparam logic [PW-1:0] PRESC_LAST = PW'(CLK_HZ - 1);
  localparam logic [PW-1:0] PRESC_HALF = PW'(CLK_HZ / 2);
  localparam logic [RW-1:0] R_ONE      = RW'(1);
  localparam logic [RW-1:0] REP_FIRE   = RW'(REPEAT_DELAY);
  localparam logic [RW-1:0] REP_RELOAD = RW'(REPEAT_DELAY - REPEAT_PERIOD);
  localparam logic [DEBOUNCE_DIV_LOG2-1:0] DB_ONE = DEBOUNCE_DIV_LOG2'(1);
  localparam logic [SCAN_DIV_LOG2-1:0]     SC_ONE = SCAN_DIV_LOG2'(1);
  localparam logic [2:0] IDX_LAST = 3'(NUM_DIGITS - 1);
  localparam logic [2:0] HH_LO    = 3'(NUM_DIGITS - 2);
  localparam logic [2:0] MM_LO    = 3'(NUM_DIGITS - 4);
  localparam logic [2:0] NIB_OFS  = (NUM_DIGITS == 4) ? 3'd2 : 3'd0;
  localparam logic [NUM_DIGITS-1:0] D_ONE = NUM_DIGITS'(1);

  if (NUM_DIGITS != 4 && NUM_DIGITS != 6) begin : g_bad_num_digits
    $error("seg_clock_ctrl: NUM_DIGITS must be 4 or 6");
  end

`ifdef SEG_CLOCK_ALARM_EN
  typedef enum logic [2:0] {S_RUN, S_SET_HOUR, S_SET_MIN, S_SET_AL_HOUR, S_SET_AL_MIN} state_t;
`else
  typedef enum logic [2:0] {S_RUN, S_SET_HOUR, S_SET_MIN} state_t;
`endif

  function automatic logic [7:0] bcd_inc(input logic [7:0] v, input logic [7:0] last);
    if (v == last) return 8'h00;
    else if (v[3:0] == 4'd9) return {v[7:4] + 4'd1, 4'h0};
    else return {v[7:4], v[3:0] + 4'd1};
  endfunction

  // seg[6:0] = g..a
  function automatic logic [6:0] seg_enc(input logic [3:0] n);
    case (n)
      4'd0: return 7'h3F;  4'd1: return 7'h06;  4'd2: return 7'h5B;  4'd3: return 7'h4F;
      4'd4: return 7'h66;  4'd5: return 7'h6D;  4'd6: return 7'h7D;  4'd7: return 7'h07;
      4'd8: return 7'h7F;  4'd9: return 7'h6F;  default: return 7'h79;
    endcase
  endfunction

  state_t state_q, state_d;
  logic [PW-1:0] presc_q, presc_d;
  logic [7:0] hh_q, hh_d, mm_q, mm_d, ss_q, ss_d;
  logic [DEBOUNCE_DIV_LOG2-1:0] deb_q, deb_d;
  logic [SCAN_DIV_LOG2-1:0] scan_div_q, scan_div_d;
  logic [2:0] scan_idx_q, scan_idx_d;
  logic [RW-1:0] rep_q, rep_d, rep_inc;
  logic set_s1_q, set_s2_q, inc_s1_q, inc_s2_q;
  logic set_smp_q, set_smp_d, inc_smp_q, inc_smp_d;
  logic deb_tick, scan_tick, sec_tick, set_press, inc_press, rep_fire, inc_evt, set_evt, tick_applied;
  logic [7:0] hh_src, mm_src, ss_src, hh_disp;
  logic [4:0] hh_bin, h12;
  logic [23:0] disp;
  logic [2:0] nib_sel;
  logic [3:0] nib;
  logic sel_hour, sel_min, blank, pm, dp;
`ifdef SEG_CLOCK_ALARM_EN
  logic [7:0] al_hh_q, al_hh_d, al_mm_q, al_mm_d;
  logic [5:0] al_cnt_q, al_cnt_d;
  logic alarm_q, alarm_d;
  assign alarm = alarm_q;
`endif

  always_comb begin
    deb_tick  = &deb_q;
    scan_tick = &scan_div_q;
    sec_tick  = (presc_q == PRESC_LAST);
    set_press = deb_tick & set_s2_q & ~set_smp_q;
    inc_press = deb_tick & inc_s2_q & ~inc_smp_q;
    deb_d     = deb_q + DB_ONE;
    set_smp_d = deb_tick ? set_s2_q : set_smp_q;
    inc_smp_d = deb_tick ? inc_s2_q : inc_smp_q;
    rep_inc   = rep_q + R_ONE;
    rep_d     = rep_q;
    rep_fire  = 1'b0;
    if (deb_tick) begin
      if (!inc_s2_q || inc_press || set_press) rep_d = '0;
      else if (rep_inc == REP_FIRE) begin
        rep_fire = 1'b1;
        rep_d    = REP_RELOAD;
      end else rep_d = rep_inc;
    end
    inc_evt = (inc_press | rep_fire) & ~set_press;
    set_evt = set_press;
`ifdef SEG_CLOCK_ALARM_EN
    // while ringing, any button only silences the alarm
    inc_evt = inc_evt & ~alarm_q;
    set_evt = set_evt & ~alarm_q;
    al_hh_d = al_hh_q;
    al_mm_d = al_mm_q;
    if (inc_evt && state_q == S_SET_AL_HOUR) al_hh_d = bcd_inc(al_hh_q, 8'h23);
    if (inc_evt && state_q == S_SET_AL_MIN)  al_mm_d = bcd_inc(al_mm_q, 8'h59);
`endif
    presc_d      = sec_tick ? '0 : presc_q + P_ONE;
    hh_d         = hh_q;
    mm_d         = mm_q;
    ss_d         = ss_q;
    state_d      = state_q;
    tick_applied = 1'b0;
    if (inc_evt && state_q == S_SET_HOUR) begin
      hh_d = bcd_inc(hh_q, 8'h23);  ss_d = 8'h00;  presc_d = '0;
    end else if (inc_evt && state_q == S_SET_MIN) begin
      mm_d = bcd_inc(mm_q, 8'h59);  ss_d = 8'h00;  presc_d = '0;
    end else if (sec_tick) begin
      tick_applied = 1'b1;
      ss_d = bcd_inc(ss_q, 8'h59);
      if (ss_q == 8'h59) begin
        mm_d = bcd_inc(mm_q, 8'h59);
        if (mm_q == 8'h59) hh_d = bcd_inc(hh_q, 8'h23);
      end
    end
    if (set_evt) begin
      case (state_q)
        S_RUN:      state_d = S_SET_HOUR;
        S_SET_HOUR: state_d = S_SET_MIN;
        S_SET_MIN: begin
`ifdef SEG_CLOCK_ALARM_EN
          state_d = S_SET_AL_HOUR;
`else
          state_d = S_RUN;
`endif
          ss_d    = 8'h00;
          presc_d = '0;
        end
`ifdef SEG_CLOCK_ALARM_EN
        S_SET_AL_HOUR: state_d = S_SET_AL_MIN;
        S_SET_AL_MIN:  state_d = S_RUN;
`endif
        default:    state_d = S_RUN;
      endcase
    end
`ifdef SEG_CLOCK_ALARM_EN
    alarm_d  = alarm_q;
    al_cnt_d = al_cnt_q;
    if (alarm_q) begin
      if (!alarm_on || set_press || inc_press) alarm_d = 1'b0;
      else if (sec_tick) begin
        if (al_cnt_q == 6'd59) alarm_d = 1'b0;
        else al_cnt_d = al_cnt_q + 6'd1;
      end
    end else if (alarm_on && tick_applied && {hh_d, mm_d, ss_d} == {al_hh_q, al_mm_q, 8'h00}) begin
      alarm_d  = 1'b1;
      al_cnt_d = 6'd0;
    end
`endif
    scan_div_d = scan_div_q + SC_ONE;
    scan_idx_d = scan_idx_q;
    if (scan_tick) scan_idx_d = (scan_idx_q == IDX_LAST) ? 3'd0 : scan_idx_q + 3'd1;
  end

  always_comb begin
    hh_src   = hh_q;
    mm_src   = mm_q;
    ss_src   = ss_q;
    sel_hour = (state_q == S_SET_HOUR);
    sel_min  = (state_q == S_SET_MIN);
`ifdef SEG_CLOCK_ALARM_EN
    if (state_q == S_SET_AL_HOUR || state_q == S_SET_AL_MIN) begin
      hh_src = al_hh_q;
      mm_src = al_mm_q;
      ss_src = 8'h00;
    end
    sel_hour = sel_hour | (state_q == S_SET_AL_HOUR);
    sel_min  = sel_min  | (state_q == S_SET_AL_MIN);
`endif
    hh_bin = 5'(hh_src[7:4]) * 5'd10 + 5'(hh_src[3:0]);
    h12    = hh_bin;
    if (hh_bin == 5'd0) h12 = 5'd12;
    else if (hh_bin > 5'd12) h12 = hh_bin - 5'd12;
    hh_disp = hh_src;
    if (mode_12h) hh_disp = (h12 >= 5'd10) ? {4'd1, 4'(h12 - 5'd10)} : {4'd0, 4'(h12)};
    pm      = (hh_src >= 8'h12);
    disp    = {hh_disp, mm_src, ss_src};
    nib_sel = scan_idx_q + NIB_OFS;
    nib     = disp[{nib_sel, 2'b00} +: 4];
    blank   = (presc_q >= PRESC_HALF) &&
              ((sel_hour && (scan_idx_q == HH_LO || scan_idx_q == HH_LO + 3'd1)) ||
               (sel_min  && (scan_idx_q == MM_LO || scan_idx_q == MM_LO + 3'd1)));
    // colon rides on the dp of the hours-units digit
    dp  = ((scan_idx_q == HH_LO) && (state_q != S_RUN || presc_q < PRESC_HALF)) ||
          ((scan_idx_q == 3'd0) && mode_12h && pm);
    seg = {dp, blank ? 7'h00 : seg_enc(nib)};
  end

  assign d        = ~(D_ONE << scan_idx_q);
  assign time_bcd = {hh_q, mm_q, ss_q};

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_RUN;       presc_q <= '0;
      hh_q <= 8'h00;          mm_q <= 8'h00;          ss_q <= 8'h00;
      deb_q <= '0;            scan_div_q <= '0;       scan_idx_q <= 3'd0;
      rep_q <= '0;            set_smp_q <= 1'b0;      inc_smp_q <= 1'b0;
      set_s1_q <= 1'b0;       set_s2_q <= 1'b0;
      inc_s1_q <= 1'b0;       inc_s2_q <= 1'b0;
`ifdef SEG_CLOCK_ALARM_EN
      al_hh_q <= 8'h00;       al_mm_q <= 8'h00;
      al_cnt_q <= 6'd0;       alarm_q <= 1'b0;
`endif
    end else begin
      state_q <= state_d;     presc_q <= presc_d;
      hh_q <= hh_d;           mm_q <= mm_d;           ss_q <= ss_d;
      deb_q <= deb_d;         scan_div_q <= scan_div_d; scan_idx_q <= scan_idx_d;
      rep_q <= rep_d;         set_smp_q <= set_smp_d; inc_smp_q <= inc_smp_d;
      set_s1_q <= btn_set;    set_s2_q <= set_s1_q;
      inc_s1_q <= btn_inc;    inc_s2_q <= inc_s1_q;
`ifdef SEG_CLOCK_ALARM_EN
      al_hh_q <= al_hh_d;     al_mm_q <= al_mm_d;
      al_cnt_q <= al_cnt_d;   alarm_q <= alarm_d;
`endif
    end
  end
endmodule
